// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: FSM encoding, default
// parameter values and the alignment-width helper.
package pc_unit_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } pc_state_e;

   localparam int          DEF_WIDTH     = 32;
   localparam int          DEF_STEP      = 4;
   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;

   // Number of low target bits that must be zero for a STEP-aligned fetch.
   function automatic int align_bits(input int step);
      return $clog2(step);
   endfunction

endpackage

// File: rtl/pc_prio_sel.sv
// Fixed-priority redirect mux: the lowest-index valid source wins.
module pc_prio_sel #(
   parameter int WIDTH   = 32,
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC*WIDTH-1:0] src_target,
   input  logic [NUM_SRC-1:0]       src_valid,
   output logic [WIDTH-1:0]         win_target,
   output logic                     any_valid
);

   always_comb begin
      win_target = '0;
      // Walk from the lowest priority up so the lowest index is written last.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (src_valid[i]) begin
            win_target = src_target[i*WIDTH +: WIDTH];
         end
      end
      any_valid = |src_valid;
   end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register with prioritised redirects, stall hold and a
// one-entry pending-redirect buffer for redirects that arrive while stalled.
module pc_next_unit
   import pc_unit_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               NUM_SRC   = 4,
   parameter int               STEP      = DEF_STEP,
   parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_SRC*WIDTH-1:0] src_target,
   input  logic [NUM_SRC-1:0]       src_valid,
   input  logic                     stall,
   output logic [WIDTH-1:0]         pc,
   output logic [WIDTH-1:0]         pc_plus_step,
   output logic                     redirect,
   output logic                     pending,
   output logic                     misalign
);

   localparam int               ALIGN      = align_bits(STEP);
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((1 << ALIGN) - 1);

   // Sources are fire-and-forget: a valid is sampled on each rising edge with
   // no ready returned, so a source that loses arbitration is simply dropped.
   logic [WIDTH-1:0] win_target;
   logic             any_valid;
   logic [WIDTH-1:0] win_aligned;
   logic             win_misalign;
   logic [WIDTH-1:0] pend_tgt;
   pc_state_e        state;

   pc_prio_sel #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC)
   ) u_prio_sel (
      .src_target (src_target),
      .src_valid  (src_valid),
      .win_target (win_target),
      .any_valid  (any_valid)
   );

   // With STEP=1 the mask is zero, so no bits are cleared and misalign stays 0.
   assign win_aligned  = win_target & ~ALIGN_MASK;
   assign win_misalign = |(win_target & ALIGN_MASK);

   assign pc_plus_step = pc + WIDTH'(STEP);
   assign pending      = (state == HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         pc       <= RESET_VEC;
         pend_tgt <= '0;
         redirect <= 1'b0;
         misalign <= 1'b0;
      end else begin
         redirect <= 1'b0;
         misalign <= 1'b0;
         case (state)
            RUN: begin
               if (!stall) begin
                  if (any_valid) begin
                     pc       <= win_aligned;
                     redirect <= 1'b1;
                     misalign <= win_misalign;
                  end else begin
                     pc <= pc_plus_step;
                  end
               end else if (any_valid) begin
                  pend_tgt <= win_aligned;
                  misalign <= win_misalign;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (stall) begin
                  // Newest redirect replaces the buffered one.
                  if (any_valid) begin
                     pend_tgt <= win_aligned;
                     misalign <= win_misalign;
                  end
               end else begin
                  redirect <= 1'b1;
                  state    <= RUN;
                  if (any_valid) begin
                     pc       <= win_aligned;
                     misalign <= win_misalign;
                  end else begin
                     pc <= pend_tgt;
                  end
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised program-counter unit: owns the PC register and selects the next fetch address from a sequential increment or one of NUM_SRC prioritised redirect sources (exception vector, branch, jump, jump-register). It sits at the front of the fetch stage and replaces the 2-input PC select mux. Adds stall handling and a one-entry pending-redirect buffer, so redirects arriving during a stall are not lost.

## Interface
Parameters:
- WIDTH, 32, PC and target width in bits.
- NUM_SRC, 4, number of redirect sources; index 0 has highest priority.
- STEP, 4, sequential increment; power of two, ≥1.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- src_target  input  NUM_SRC*WIDTH  packed redirect targets; source i occupies bits [i*WIDTH +: WIDTH].
- src_valid  input  NUM_SRC  per-source redirect request, sampled each rising edge.
- stall  input  1  hold PC (fetch back-pressure).
- pc  output  WIDTH  current fetch address, registered.
- pc_plus_step  output  WIDTH  pc + STEP, combinational from pc, modulo 2^WIDTH.
- redirect  output  1  registered; 1 for the cycle in which pc holds a redirect target (direct or released from pending).
- pending  output  1  registered; pending buffer occupied.
- misalign  output  1  registered one-cycle pulse; the loaded target had nonzero bits below log2(STEP).

## Operation
- Priority select: winner = lowest index i with src_valid[i]=1; any_valid = |src_valid.
- Loaded targets have bits [log2(STEP)-1:0] forced to zero; misalign pulses if any of those bits was 1. STEP=1 disables alignment and misalign stays 0.
- FSM states: RUN (pending=0) and HOLD (pending=1, buffer pend_tgt valid).
- RUN, stall=0, any_valid=1: pc ← winner target; redirect=1; stay RUN.
- RUN, stall=0, any_valid=0: pc ← pc+STEP; redirect=0.
- RUN, stall=1, any_valid=1: pc holds; pend_tgt ← winner target; → HOLD.
- RUN, stall=1, any_valid=0: pc holds; redirect=0.
- HOLD, stall=1, any_valid=1: pend_tgt ← new winner target (newest overwrites); stay HOLD.
- HOLD, stall=1, any_valid=0: hold everything.
- HOLD, stall=0, any_valid=1: pc ← new winner target; pending discarded; redirect=1; → RUN.
- HOLD, stall=0, any_valid=0: pc ← pend_tgt; redirect=1; → RUN.
- Wrap-around: pc+STEP at 2^WIDTH-STEP yields 0, no flag.
- misalign is computed at capture time: for buffered targets it pulses when the target enters pend_tgt, not again at release.

## Timing
- Reset (rst_n=0, asynchronous): pc=RESET_VEC, redirect=0, pending=0, misalign=0, pend_tgt=0, state RUN. Takes effect immediately, mid-stall or mid-HOLD included; the first update happens on the first rising edge after rst_n rises.
- Redirect latency: src_valid high at edge N (stall=0) → pc = target after edge N, visible in cycle N+1.
- Pending release: stall falls before edge M → pc = pend_tgt after edge M.
- redirect and misalign are one-cycle pulses; they deassert on the following edge unless re-triggered.
- src_valid and src_target are sampled only at rising edges; no handshake back to sources. A source that is not selected on a cycle is dropped.

## Structure
- Shared package/include pc_unit_pkg: FSM state encoding (RUN, HOLD), default RESET_VEC and STEP constants, and a log2 helper constant for the alignment mask.
- One sub-module, pc_prio_sel: parametrised NUM_SRC×WIDTH priority mux producing the winner target and any_valid. Top level holds the FSM, the PC register and the pending buffer.

## Test plan
- Reset and run: rst_n low→high, no stimulus, 3 cycles → pc = 0x0, 0x4, 0x8, 0xC; redirect=0.
- Priority: src_valid=4'b0110, targets[1]=0x100, targets[2]=0x200 → next pc=0x100, redirect=1 for one cycle, then pc=0x104.
- Stall capture: stall=1, src_valid[2]=1 with target 0x400 for one cycle, stall held 3 cycles → pc unchanged, pending=1; stall drops → pc=0x400, redirect=1, pending=0.
- Overwrite and override: in HOLD with pend_tgt=0x400, apply src_valid[0] target 0x80 while stalled → release pc=0x80. Separately, release with src_valid[3]=0x900 on the stall-release edge → pc=0x900 and the buffer is discarded.
- Wrap and misalign: pc=0xFFFF_FFFC, no stall → pc=0x0. A redirect target of 0x203 → pc=0x200 and misalign=1 for one cycle.
- Async reset mid-HOLD: assert rst_n low between edges while pending=1 → pc=RESET_VEC and pending=0 immediately, without waiting for a clock edge.
